// File: rtl/ahb_grant_ctrl.sv
// Round-robin AHB bus-ownership controller with burst/lock hold, parking and tenure limit.
// Grant registered (1-cycle request->grant); all state frozen while hready is low.
module ahb_grant_ctrl #(
  parameter int MANAGERS = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [MANAGERS-1:0]         requestV,
  input  logic [MANAGERS-1:0]         lockV,
  input  logic                        hready,
  input  logic [1:0]                  htrans,
  output logic [MANAGERS-1:0]         grantedV,
  output logic [$clog2(MANAGERS)-1:0] owner_idx,
  output logic [$clog2(MANAGERS)-1:0] dphase_idx,
  output logic                        locked
);

  localparam int IDXW = $clog2(MANAGERS);
  localparam int TW   = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] PARK   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [1:0] HT_IDLE = 2'b00;

  logic [1:0]          state, state_nxt;
  logic [IDXW-1:0]     owner_nxt;
  logic [IDXW-1:0]     win_idx;
  logic [TW-1:0]       tenure;
  logic [MANAGERS-1:0] gnt_nxt;

  logic any_req, owner_req, owner_lock, others_req;
  logic idle, sp, ten_sat, grant_chg;

  assign any_req    = |requestV;
  assign owner_req  = requestV[owner_idx];
  assign owner_lock = lockV[owner_idx];
  assign others_req = |(requestV & ~grantedV);
  assign idle       = (htrans == HT_IDLE);
  assign sp         = hready & (idle | ~owner_req);
  assign ten_sat    = (tenure == TW'(MAX_HOLD));
  assign grant_chg  = (owner_nxt != owner_idx);

  // Descending scan so the smallest rotational distance from the owner wins;
  // the owner itself is only chosen when nobody else is requesting.
  always_comb begin
    int tmp;
    tmp     = 0;
    win_idx = owner_idx;
    for (int i = MANAGERS - 1; i >= 1; i--) begin
      tmp = int'(owner_idx) + i;
      if (tmp >= MANAGERS) tmp = tmp - MANAGERS;
      if (requestV[tmp[IDXW-1:0]]) win_idx = tmp[IDXW-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_idx;
    if (hready) begin
      case (state)
        PARK: begin
          if (sp && any_req) begin
            owner_nxt = win_idx;
            state_nxt = lockV[win_idx] ? LOCKED : ACTIVE;
          end else if (owner_req) begin
            state_nxt = owner_lock ? LOCKED : ACTIVE;
          end
        end
        ACTIVE: begin
          if ((ten_sat && idle && others_req) || (sp && !owner_req)) begin
            if (any_req) begin
              owner_nxt = win_idx;
              state_nxt = lockV[win_idx] ? LOCKED : ACTIVE;
            end else begin
              state_nxt = PARK;
            end
          end else if (owner_lock) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // Lock release is itself a switch point (htrans is IDLE here).
          if (!owner_lock && idle) begin
            if (owner_req) begin
              state_nxt = ACTIVE;
            end else if (any_req) begin
              owner_nxt = win_idx;
              state_nxt = lockV[win_idx] ? LOCKED : ACTIVE;
            end else begin
              state_nxt = PARK;
            end
          end
        end
        default: state_nxt = PARK;
      endcase
    end
  end

  always_comb begin
    gnt_nxt            = '0;
    gnt_nxt[owner_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= PARK;
      owner_idx  <= '0;
      grantedV   <= MANAGERS'(1);
      dphase_idx <= '0;
    end else begin
      state     <= state_nxt;
      owner_idx <= owner_nxt;
      grantedV  <= gnt_nxt;
      if (hready) dphase_idx <= owner_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tenure <= '0;
    end else if (grant_chg || state != ACTIVE) begin
      tenure <= '0;
    end else if (hready && htrans[1] && others_req && !ten_sat) begin
      tenure <= tenure + 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// Scoreboard bench for ahb_grant_ctrl (MANAGERS=4, MAX_HOLD=4).
module tb_ahb_grant_ctrl;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       clk;
  logic       resetn;
  logic [3:0] requestV;
  logic [3:0] lockV;
  logic       hready;
  logic [1:0] htrans;
  logic [3:0] grantedV;
  logic [1:0] owner_idx;
  logic [1:0] dphase_idx;
  logic       locked;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [1:0] owner;
    logic       lck;
    logic [1:0] dph;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] cur_owner;
  logic [1:0] cur_dph;

  ahb_grant_ctrl #(.MANAGERS(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .requestV  (requestV),
    .lockV     (lockV),
    .hready    (hready),
    .htrans    (htrans),
    .grantedV  (grantedV),
    .owner_idx (owner_idx),
    .dphase_idx(dphase_idx),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; expected result is queued now and checked after the edge.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                      input logic hr, input logic [1:0] tr,
                      input logic [1:0] eo, input logic el);
    exp_t       e;
    logic [3:0] eg;
    e.owner = eo;
    e.lck   = el;
    e.dph   = hr ? cur_owner : cur_dph;
    sb_q.push_back(e);
    requestV = req;
    lockV    = lck;
    hready   = hr;
    htrans   = tr;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e  = sb_q.pop_front();
      eg = 4'b0001 << e.owner;
      check({tag, "_gnt"}, 32'(grantedV), 32'(eg));
      check({tag, "_own"}, 32'(owner_idx), 32'(e.owner));
      check({tag, "_dph"}, 32'(dphase_idx), 32'(e.dph));
      check({tag, "_lck"}, 32'(locked), 32'(e.lck));
      cur_owner = e.owner;
      cur_dph   = e.dph;
    end
  endtask

  task automatic do_reset(input string tag);
    requestV = '0;
    lockV    = '0;
    hready   = 1'b1;
    htrans   = IDLE;
    resetn   = 1'b1;
    #1;
    resetn = 1'b0;
    #2;
    check({tag, "_gnt"}, 32'(grantedV), 32'h1);
    check({tag, "_own"}, 32'(owner_idx), 32'h0);
    check({tag, "_dph"}, 32'(dphase_idx), 32'h0);
    check({tag, "_lck"}, 32'(locked), 32'h0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    cur_owner = 2'd0;
    cur_dph   = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cur_owner   = 2'd0;
    cur_dph     = 2'd0;

    // Parking, first grant, dphase lag and hready hold.
    do_reset("rst1");
    step("park",    4'b0000, 4'b0000, 1'b1, IDLE, 2'd0, 1'b0);
    step("gnt2",    4'b0100, 4'b0000, 1'b1, IDLE, 2'd2, 1'b0);
    step("stall",   4'b0100, 4'b0000, 1'b0, IDLE, 2'd2, 1'b0);
    step("dph2",    4'b0100, 4'b0000, 1'b1, IDLE, 2'd2, 1'b0);

    // Round robin: each owner drops its request at IDLE.
    do_reset("rst2");
    step("rr1",     4'b1110, 4'b0000, 1'b1, IDLE, 2'd1, 1'b0);
    step("rr2",     4'b1101, 4'b0000, 1'b1, IDLE, 2'd2, 1'b0);
    step("rr3",     4'b1011, 4'b0000, 1'b1, IDLE, 2'd3, 1'b0);
    step("rr0",     4'b0111, 4'b0000, 1'b1, IDLE, 2'd0, 1'b0);

    // Burst of owner 1 with manager 3 waiting and a two-cycle stall.
    do_reset("rst3");
    step("b_gnt",   4'b0010, 4'b0000, 1'b1, IDLE,   2'd1, 1'b0);
    step("b_ns",    4'b0010, 4'b0000, 1'b1, NONSEQ, 2'd1, 1'b0);
    step("b_s1w",   4'b1010, 4'b0000, 1'b0, SEQ,    2'd1, 1'b0);
    step("b_s1w2",  4'b1010, 4'b0000, 1'b0, SEQ,    2'd1, 1'b0);
    step("b_s1",    4'b1010, 4'b0000, 1'b1, SEQ,    2'd1, 1'b0);
    step("b_s2",    4'b1010, 4'b0000, 1'b1, SEQ,    2'd1, 1'b0);
    step("b_s3",    4'b1010, 4'b0000, 1'b1, SEQ,    2'd1, 1'b0);
    step("b_idlew", 4'b1000, 4'b0000, 1'b0, IDLE,   2'd1, 1'b0);
    step("b_hand",  4'b1000, 4'b0000, 1'b1, IDLE,   2'd3, 1'b0);

    // Locked owner 2 ignores competition until lock drops at IDLE.
    do_reset("rst4");
    step("l_gnt",   4'b0100, 4'b0100, 1'b1, IDLE, 2'd2, 1'b1);
    for (int i = 0; i < 20; i++)
      step("l_hold", 4'b1111, 4'b0100, 1'b1, (i % 2 == 0) ? NONSEQ : IDLE, 2'd2, 1'b1);
    step("l_nsdrop", 4'b1011, 4'b0000, 1'b1, NONSEQ, 2'd2, 1'b1);
    step("l_exit",   4'b1011, 4'b0000, 1'b1, IDLE,   2'd3, 1'b0);

    // Tenure limit: owner 0 keeps requesting, manager 1 waits.
    do_reset("rst5");
    step("t_own",   4'b0001, 4'b0000, 1'b1, IDLE, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("t_ns",   4'b0011, 4'b0000, 1'b1, NONSEQ, 2'd0, 1'b0);
      step("t_idle", 4'b0011, 4'b0000, 1'b1, IDLE, (k == 3) ? 2'd1 : 2'd0, 1'b0);
    end

    // Asynchronous reset in the middle of a locked burst.
    do_reset("rst6");
    step("m_lock",  4'b0010, 4'b0010, 1'b1, IDLE,   2'd1, 1'b1);
    step("m_ns",    4'b0010, 4'b0010, 1'b1, NONSEQ, 2'd1, 1'b1);
    step("m_seq",   4'b0010, 4'b0010, 1'b1, SEQ,    2'd1, 1'b1);
    do_reset("rst_mid");
    step("m_after", 4'b0000, 4'b0000, 1'b1, IDLE, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_grant_ctrl.md
# ahb_grant_ctrl

Registered bus-ownership controller for the AHB multi-manager interconnect. It arbitrates between `MANAGERS` requesters with rotating (round-robin) priority, holds the grant across bursts and locked sequences, and parks the bus on the last owner when no-one requests. It also tracks which manager owns the data phase, so the read-data/response mux follows the address-phase grant by one accepted transfer. A tenure limit prevents one continuously requesting manager from starving the others.

## Interface
- `MANAGERS`, 4: number of requesting managers (≥2)
- `MAX_HOLD`, 16: maximum accepted transfers an unlocked owner may keep the bus while another manager waits (≥1)
- `clk`  in  1  bus clock, all state on rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `requestV`  in  MANAGERS  per-manager bus request (level)
- `lockV`  in  MANAGERS  per-manager locked-sequence request
- `hready`  in  1  bus ready from the slave mux
- `htrans`  in  2  transfer type of the currently granted manager (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- `grantedV`  out  MANAGERS  address-phase grant, one-hot, registered
- `owner_idx`  out  $clog2(MANAGERS)  binary index of `grantedV`
- `dphase_idx`  out  $clog2(MANAGERS)  manager owning the current data phase
- `locked`  out  1  high while in LOCKED state

## Operation
- States: PARK (owner not requesting), ACTIVE (owner requesting, unlocked), LOCKED.
- Switch point `sp` = `hready` & (`htrans`==IDLE | !`requestV[owner]`). No grant change outside `sp`; SEQ/BUSY beats of a requesting owner are never broken.
- Round-robin search at `sp`: candidates `owner+1, owner+2, …` wrapping modulo MANAGERS, `owner` last. First requesting candidate wins.
- PARK: at `sp`, if any request → grant winner, go ACTIVE (or LOCKED if winner's `lockV` high). No request → keep grant, stay PARK.
- ACTIVE: owner keeps bus while requesting unless tenure expired. At `sp` with owner's `requestV` low → rotate to winner (→ACTIVE/LOCKED) or stay owner (→PARK) if none. Owner asserts `lockV` while granted → LOCKED next cycle.
- LOCKED: grant frozen regardless of other requests and tenure. Exit only when `lockV[owner]`=0 and `hready` & `htrans`==IDLE; then behave as ACTIVE switch point that same cycle.
- Tenure counter: cleared on every grant change and in PARK/LOCKED; increments on each ACTIVE cycle with `hready` & `htrans`∈{NONSEQ,SEQ} while some other manager requests; saturates at MAX_HOLD. When saturated and `hready` & `htrans`==IDLE, force rotation to the next requester even if owner still requests.
- `dphase_idx` loads `owner_idx` on every cycle with `hready`=1; holds otherwise.
- Requests from non-owners with `lockV` high but `requestV` low are ignored.

## Timing
- Reset (async, `resetn`=0): `grantedV`=…0001, `owner_idx`=0, `dphase_idx`=0, `locked`=0, state PARK, tenure 0.
- Grant latency: request seen in cycle n with `sp` true → `grantedV` changes at edge ending n, visible cycle n+1. Minimum one cycle; no combinational path request→grant.
- `hready`=0 in cycle n: no grant, state, or `dphase_idx` change in that edge.
- `dphase_idx` lags `owner_idx` by one `hready`-qualified cycle.
- Simultaneous requests: lowest rotational distance from owner wins; owner itself only if no other requests.
- Reset mid-burst or mid-lock: immediate return to reset values; no lock state survives.
- `grantedV` always exactly one-hot, including reset and PARK.

## Test plan
- Reset, no requests: `grantedV`=0001, PARK; `requestV`=0100 with `htrans`=IDLE,`hready`=1 → `grantedV`=0100 next cycle, `dphase_idx`=2 one cycle later.
- `requestV`=1111, owner 0 drops request at each IDLE → grant order 0,1,2,3,0.
- Owner 1 in 4-beat burst (NONSEQ,SEQ,SEQ,SEQ), manager 3 requests mid-burst, `hready` low 2 cycles on beat 2 → grant stays 0010 until IDLE, then 1000; `dphase_idx` frozen during stalls.
- Owner 2 asserts `lockV`=0100, others request for 20 cycles → `grantedV`=0100, `locked`=1 throughout; lock drop + IDLE → grant moves to 3.
- MAX_HOLD=4, owner 0 requests continuously with single NONSEQ transfers separated by IDLE, manager 1 requests → handover to 0010 at first IDLE after 4 counted transfers.
- Assert `resetn`=0 during LOCKED burst → outputs return to reset values asynchronously, `locked`=0.
